// File: rtl/pi_pkg.sv
// Shared types and constants for the PI duty-cycle controller.
package pi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ERR   = 3'd1,
      INTEG = 3'd2,
      SUM   = 3'd3,
      SAT   = 3'd4,
      OUT   = 3'd5
   } state_t;

   localparam int unsigned PW_W    = 8;
   localparam int unsigned ERR_W   = 9;
   localparam int unsigned PROD_W  = PW_W + ERR_W + 1;
   localparam int unsigned INTEG_W = 20;
   localparam int unsigned SUM_W   = 21;

   localparam logic signed [INTEG_W-1:0] INTEG_MAX = {1'b0, {(INTEG_W-1){1'b1}}};
   localparam logic signed [INTEG_W-1:0] INTEG_MIN = {1'b1, {(INTEG_W-1){1'b0}}};
   localparam logic [PW_W-1:0]           PW_MAX    = '1;
   localparam logic [PW_W-1:0]           PW_MIN    = '0;

   // Clamp a two-bit-wider integrator candidate into the integrator range.
   function automatic logic signed [INTEG_W-1:0] integ_clamp(input logic signed [INTEG_W+1:0] v);
      if (!v[INTEG_W+1] && (|v[INTEG_W:INTEG_W-1]))
         return INTEG_MAX;
      else if (v[INTEG_W+1] && !(&v[INTEG_W:INTEG_W-1]))
         return INTEG_MIN;
      else
         return v[INTEG_W-1:0];
   endfunction

endpackage

// File: rtl/pi_duty_if.sv
// Control/status bundle between a controller user and pi_duty.
interface pi_duty_if;
   import pi_pkg::*;

   logic            enable;
   logic            sample;
   logic [PW_W-1:0] setpoint;
   logic [PW_W-1:0] feedback;
   logic [PW_W-1:0] PW;
   logic            valid;
   logic            busy;
   logic            overrun;

   modport master (
      output enable, sample, setpoint, feedback,
      input  PW, valid, busy, overrun
   );

   modport slave (
      input  enable, sample, setpoint, feedback,
      output PW, valid, busy, overrun
   );

endinterface

// File: rtl/pi_sat.sv
// Clamp the signed controller sum to an 8-bit duty word with range flags.
module pi_sat
   import pi_pkg::*;
(
   input  logic signed [SUM_W-1:0] u,
   output logic [PW_W-1:0]         pw,
   output logic                    hi,
   output logic                    lo
);

   // Negative sums clamp to zero, sums above the duty range clamp to full scale.
   always_comb begin
      lo = u[SUM_W-1];
      hi = !u[SUM_W-1] && (|u[SUM_W-2:PW_W]);
      if (lo)
         pw = PW_MIN;
      else if (hi)
         pw = PW_MAX;
      else
         pw = u[PW_W-1:0];
   end

endmodule

// File: rtl/pi_duty.sv
// Sampled PI controller producing a registered duty word for a pwm block.
// One pipeline step per state: error, integrator candidate, sum, clamp, commit.
module pi_duty
   import pi_pkg::*;
#(
   parameter logic [7:0]  KP    = 8'd16,
   parameter logic [7:0]  KI    = 8'd2,
   parameter int unsigned SHIFT = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   pi_duty_if.slave ctl
);

   state_t state, state_nx;
   logic   accept, commit;

   logic [PW_W-1:0]           sp_q, fb_q;
   logic signed [ERR_W-1:0]   e_q, e_c;
   logic [PROD_W-1:0]         kie_c, kpe_c;
   logic signed [INTEG_W+1:0] integ_sum;
   logic signed [INTEG_W-1:0] integ, integ_c_n, integ_c_q;
   logic signed [SUM_W-1:0]   u_full, u_c, u_q;
   logic [PW_W-1:0]           sat_pw, pw_c_q, pw_q;
   logic                      sat_hi, sat_lo, take_c, take_q;
   logic                      e_pos, e_neg;
   logic                      valid_q, overrun_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next state plus accept/commit strobes; enable low always returns to IDLE.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      commit   = 1'b0;
      if (!ctl.enable) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (ctl.sample) begin
                  accept   = 1'b1;
                  state_nx = ERR;
               end
            end
            ERR:     state_nx = INTEG;
            INTEG:   state_nx = SUM;
            SUM:     state_nx = SAT;
            SAT:     state_nx = OUT;
            OUT: begin
               commit   = 1'b1;
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Products are taken on operands pre-extended to PROD_W bits: the low bits of an
   // unsigned product equal the two's-complement product, so no signed casts are needed.
   always_comb begin
      e_c       = $signed({1'b0, sp_q} - {1'b0, fb_q});
      kie_c     = {{(PROD_W-8){1'b0}}, KI} * {{(PROD_W-ERR_W){e_q[ERR_W-1]}}, e_q};
      kpe_c     = {{(PROD_W-8){1'b0}}, KP} * {{(PROD_W-ERR_W){e_q[ERR_W-1]}}, e_q};
      integ_sum = $signed({{2{integ[INTEG_W-1]}}, integ})
                + $signed({{(INTEG_W+2-PROD_W){kie_c[PROD_W-1]}}, kie_c});
      integ_c_n = integ_clamp(integ_sum);
      u_full    = $signed({{(SUM_W-PROD_W){kpe_c[PROD_W-1]}}, kpe_c})
                + $signed({integ_c_q[INTEG_W-1], integ_c_q});
      u_c       = u_full >>> SHIFT;
   end

   pi_sat u_sat (
      .u  (u_q),
      .pw (sat_pw),
      .hi (sat_hi),
      .lo (sat_lo)
   );

   // Anti-windup: accept the new integrator only when it does not push further into a limit.
   always_comb begin
      e_neg  = e_q[ERR_W-1];
      e_pos  = !e_q[ERR_W-1] && (|e_q);
      take_c = (!sat_hi && !sat_lo) || (sat_hi && e_neg) || (sat_lo && e_pos);
   end

   // Pipeline registers, each loaded in its own state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q      <= '0;
         fb_q      <= '0;
         e_q       <= '0;
         integ_c_q <= '0;
         u_q       <= '0;
         pw_c_q    <= '0;
         take_q    <= 1'b0;
      end else begin
         if (accept) begin
            sp_q <= ctl.setpoint;
            fb_q <= ctl.feedback;
         end
         if (ctl.enable) begin
            case (state)
               ERR:     e_q       <= e_c;
               INTEG:   integ_c_q <= integ_c_n;
               SUM:     u_q       <= u_c;
               SAT: begin
                  pw_c_q <= sat_pw;
                  take_q <= take_c;
               end
               default: ;
            endcase
         end
      end
   end

   // Committed controller state and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pw_q      <= '0;
         integ     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (ctl.enable && ctl.sample && (state != IDLE))
            overrun_q <= 1'b1;
         if (!ctl.enable) begin
            pw_q    <= '0;
            integ   <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= commit;
            if (commit) begin
               pw_q <= pw_c_q;
               if (take_q)
                  integ <= integ_c_q;
            end
         end
      end
   end

   assign ctl.PW      = pw_q;
   assign ctl.valid   = valid_q;
   assign ctl.busy    = (state != IDLE);
   assign ctl.overrun = overrun_q;

endmodule
